// File: rtl/tao_co_kiemtra_if.sv
// tao_co_kiemtra_if: frame-checker handshake bundle
// master drives start_i/valid_i/data_i; slave (the checker) drives busy_o,
// fl_check_o (end-of-frame strobe), fl_ref_o (pass flag), err_cnt_o (mismatches)
interface tao_co_kiemtra_if #(
    parameter int WIDTH = 8,
    parameter int LEN   = 16
);
    localparam int CW = $clog2(LEN + 1);
    logic             start_i;
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             busy_o;
    logic             fl_check_o;
    logic             fl_ref_o;
    logic [CW-1:0]    err_cnt_o;
    modport master (output start_i, valid_i, data_i, input busy_o, fl_check_o, fl_ref_o, err_cnt_o);
    modport slave  (input start_i, valid_i, data_i, output busy_o, fl_check_o, fl_ref_o, err_cnt_o);
endinterface

// File: rtl/tao_co_kiemtra.sv
// tao_co_kiemtra: frame checker comparing LEN words against a Galois-LFSR reference
// clk_i/rst_i: clock and synchronous active-high reset
// bus: start_i/valid_i/data_i in; busy_o, fl_check_o, fl_ref_o, err_cnt_o out
module tao_co_kiemtra #(
    parameter int               WIDTH = 8,
    parameter int               LEN   = 16,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input logic              clk_i,
    input logic              rst_i,
    tao_co_kiemtra_if.slave  bus
);
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] exp_q, exp_n;
    logic [CW-1:0]    word_q, word_n, err_q, err_n;
    logic             ref_q, ref_n, check_q;
    logic             take, miss, load, last;
    always_comb begin
        take    = state == RUN && bus.valid_i;
        miss    = take && bus.data_i != exp_q;
        load    = bus.start_i && state != RUN;
        last    = take && word_q == LAST;
        state_n = last ? DONE : load ? RUN : state == DONE ? IDLE : state;
        exp_n   = take ? (exp_q >> 1) ^ (exp_q[0] ? TAPS : '0) : load ? SEED : exp_q;
        word_n  = take ? word_q + CW'(1) : load ? '0 : word_q;
        err_n   = take ? err_q + CW'(miss) : load ? '0 : err_q;
        // pass flag is settled together with the strobe so both are final in DONE
        ref_n   = last ? err_n == '0 : load ? 1'b0 : ref_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            exp_q   <= SEED;
            word_q  <= '0;
            err_q   <= '0;
            ref_q   <= 1'b0;
            check_q <= 1'b0;
        end else begin
            state   <= state_n;
            exp_q   <= exp_n;
            word_q  <= word_n;
            err_q   <= err_n;
            ref_q   <= ref_n;
            check_q <= state_n == DONE;
        end
    end
    assign bus.busy_o     = state == RUN;
    assign bus.fl_check_o = check_q;
    assign bus.fl_ref_o   = ref_q;
    assign bus.err_cnt_o  = err_q;
endmodule
